// File: rtl/exec_seq.sv
// Execution-phase state sequencer: one-hot P-D execution state, advance on got/mem_ok,
// kc/alarm/seq_err pulses. Optional memory-state timeout is enabled by EXEC_TIMEOUT_EN.
module exec_seq #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_sys,
    input  logic clr,
    input  logic start,
    input  logic nef,
    input  logic abort,
    input  logic got,
    input  logic ewe,
    input  logic ewx,
    input  logic ewa,
    input  logic ewz,
    input  logic ew$,
    input  logic ewr,
    input  logic eww,
    input  logic ewm,
    input  logic ewp,
    input  logic ekc_1,
    input  logic ekc_2,
    input  logic mem_ok,
    input  logic mem_no,
    output logic pp,
    output logic we,
    output logic wx,
    output logic wa,
    output logic wz,
    output logic w$,
    output logic wr,
    output logic ww,
    output logic wm,
    output logic wp,
    output logic mem_req,
    output logic kc,
    output logic alarm,
    output logic seq_err
);

    localparam logic [9:0] ST_IDLE = 10'b00_0000_0000;
    localparam logic [9:0] ST_PP   = 10'b00_0000_0001;
    localparam logic [9:0] ST_WE   = 10'b00_0000_0010;
    localparam logic [9:0] ST_WX   = 10'b00_0000_0100;
    localparam logic [9:0] ST_WA   = 10'b00_0000_1000;
    localparam logic [9:0] ST_WZ   = 10'b00_0001_0000;
    localparam logic [9:0] ST_WS   = 10'b00_0010_0000;
    localparam logic [9:0] ST_WR   = 10'b00_0100_0000;
    localparam logic [9:0] ST_WW   = 10'b00_1000_0000;
    localparam logic [9:0] ST_WM   = 10'b01_0000_0000;
    localparam logic [9:0] ST_WP   = 10'b10_0000_0000;
    localparam logic [9:0] ST_MEM  = ST_WR | ST_WW | ST_WM;

    // True when two or more bits of the vector are set.
    function automatic logic multi_hot(input logic [9:0] v);
        multi_hot = ((v & (v - 10'd1)) != 10'd0);
    endfunction

    // Fixed-priority pick among enter-state requests (WP highest, W$ lowest).
    function automatic logic [9:0] pick_req(input logic [9:0] r);
        if (r[9])      pick_req = ST_WP;
        else if (r[6]) pick_req = ST_WR;
        else if (r[7]) pick_req = ST_WW;
        else if (r[8]) pick_req = ST_WM;
        else if (r[1]) pick_req = ST_WE;
        else if (r[2]) pick_req = ST_WX;
        else if (r[3]) pick_req = ST_WA;
        else if (r[4]) pick_req = ST_WZ;
        else if (r[5]) pick_req = ST_WS;
        else           pick_req = ST_IDLE;
    endfunction

    logic [9:0] state_r, state_s;
    logic       kc_r, kc_s, alarm_r, alarm_s, err_r, err_s;
    logic [9:0] req_s, adv_state_s;
    logic       ekc_s, mem_st_s, adv_kc_s, adv_err_s;

`ifdef EXEC_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_r, cnt_s;
`endif

    assign req_s    = {ewp, ewm, eww, ewr, ew$, ewz, ewa, ewx, ewe, 1'b0};
    assign ekc_s    = ekc_1 | ekc_2;
    assign mem_st_s = ((state_r & ST_MEM) != 10'd0);

    // Resolve the destination of an advance from the sampled requests.
    always_comb begin
        adv_state_s = ST_IDLE;
        adv_kc_s    = 1'b0;
        adv_err_s   = multi_hot(req_s) | (ekc_s & (req_s != 10'd0));
        if (ekc_s) begin
            adv_kc_s = 1'b1;
        end else if (req_s != 10'd0) begin
            adv_state_s = pick_req(req_s);
        end else begin
            adv_err_s = 1'b1;
        end
    end

    // Next-state and pulse generation.
    always_comb begin
        state_s = state_r;
        kc_s    = 1'b0;
        alarm_s = 1'b0;
        err_s   = 1'b0;
`ifdef EXEC_TIMEOUT_EN
        cnt_s   = cnt_r;
`endif
        if (abort) begin
            state_s = ST_IDLE;
        end else if (state_r == ST_IDLE) begin
            if (start && !nef) begin
                state_s = ST_PP;
            end else begin
                kc_s = start & nef;
            end
        end else begin
            err_s = start;
            if ((mem_st_s && mem_no) ) begin
                state_s = ST_IDLE;
                alarm_s = 1'b1;
            end else if ((mem_st_s && mem_ok) || (!mem_st_s && got)) begin
                state_s = adv_state_s;
                kc_s    = adv_kc_s;
                err_s   = start | adv_err_s;
`ifdef EXEC_TIMEOUT_EN
                cnt_s   = 8'd0;
`endif
            end else begin
`ifdef EXEC_TIMEOUT_EN
                // Waiting memory state: exit with alarm the cycle the limit is reached.
                if (mem_st_s && (cnt_r >= TO_LAST)) begin
                    state_s = ST_IDLE;
                    alarm_s = 1'b1;
                end else if (mem_st_s && (cnt_r != 8'hFF)) begin
                    cnt_s = cnt_r + 8'd1;
                end else begin
                    cnt_s = cnt_r;
                end
`else
                state_s = state_r;
`endif
            end
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk_sys or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
            kc_r    <= 1'b0;
            alarm_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            kc_r    <= kc_s;
            alarm_r <= alarm_s;
            err_r   <= err_s;
        end
    end

`ifdef EXEC_TIMEOUT_EN
    // Memory-state wait counter.
    always_ff @(posedge clk_sys or posedge clr) begin
        if (clr) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_s;
        end
    end
`endif

    assign {wp, wm, ww, wr, w$, wz, wa, wx, we, pp} = state_r;
    assign mem_req = mem_st_s;
    assign kc      = kc_r;
    assign alarm   = alarm_r;
    assign seq_err = err_r;

endmodule

// File: tb/tb_exec_seq.sv
// Directed self-checking bench for exec_seq; timeout expectations follow EXEC_TIMEOUT_EN.
module tb_exec_seq;

    logic clk_sys = 1'b0;
    logic clr, start, nef, abort, got;
    logic ewe, ewx, ewa, ewz, ew$, ewr, eww, ewm, ewp, ekc_1, ekc_2;
    logic mem_ok, mem_no;
    logic pp, we, wx, wa, wz, w$, wr, ww, wm, wp, mem_req, kc, alarm, seq_err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [9:0] S_IDLE = 10'd0;
    localparam logic [9:0] S_PP   = 10'd1;
    localparam logic [9:0] S_WA   = 10'd8;
    localparam logic [9:0] S_WS   = 10'd32;
    localparam logic [9:0] S_WR   = 10'd64;
    localparam logic [9:0] S_WW   = 10'd128;
    localparam logic [9:0] S_WP   = 10'd512;

    exec_seq #(.TIMEOUT_CYCLES(4)) dut (
        .clk_sys(clk_sys), .clr(clr), .start(start), .nef(nef), .abort(abort), .got(got),
        .ewe(ewe), .ewx(ewx), .ewa(ewa), .ewz(ewz), .ew$(ew$), .ewr(ewr), .eww(eww),
        .ewm(ewm), .ewp(ewp), .ekc_1(ekc_1), .ekc_2(ekc_2), .mem_ok(mem_ok), .mem_no(mem_no),
        .pp(pp), .we(we), .wx(wx), .wa(wa), .wz(wz), .w$(w$), .wr(wr), .ww(ww), .wm(wm),
        .wp(wp), .mem_req(mem_req), .kc(kc), .alarm(alarm), .seq_err(seq_err)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [9:0] st();
        st = {wp, wm, ww, wr, w$, wz, wa, wx, we, pp};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle_in();
        start = 1'b0; nef = 1'b0; abort = 1'b0; got = 1'b0;
        {ewe, ewx, ewa, ewz, ew$, ewr, eww, ewm, ewp, ekc_1, ekc_2} = 11'd0;
        mem_ok = 1'b0; mem_no = 1'b0;
    endtask

    // One clock edge, then release all pulse inputs.
    task automatic tick();
        @(posedge clk_sys);
        #1;
        idle_in();
    endtask

    task automatic go_pp();
        start = 1'b1; tick();
    endtask

    initial begin
        int bad;
        idle_in();
        clr = 1'b1;
        tick();
        chk("rst_state", st(), S_IDLE);
        chk("rst_out", {mem_req, kc, alarm, seq_err}, 4'd0);
        clr = 1'b0;
        tick();

        // 1: PP -> WA -> W$ -> IDLE with kc once
        go_pp();
        chk("t1_pp", st(), S_PP);
        got = 1'b1; ewa = 1'b1; tick();
        chk("t1_wa", {st(), kc, seq_err}, {S_WA, 2'b00});
        got = 1'b1; ew$ = 1'b1; tick();
        chk("t1_ws", {st(), kc, seq_err}, {S_WS, 2'b00});
        got = 1'b1; ekc_1 = 1'b1; tick();
        chk("t1_end", {st(), kc, seq_err}, {S_IDLE, 2'b10});
        tick();
        chk("t1_kc_once", kc, 1'b0);

        // 2: ineffective instruction
        start = 1'b1; nef = 1'b1; tick();
        chk("t2_kc", {st(), kc, mem_req}, {S_IDLE, 2'b10});
        tick();
        chk("t2_after", kc, 1'b0);

        // 3: memory handshakes
        go_pp();
        got = 1'b1; ewr = 1'b1; tick();
        chk("t3_wr", {st(), mem_req}, {S_WR, 1'b1});
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            got = (i == 2); ewa = (i == 2);
            tick();
            if (st() != S_WR || mem_req !== 1'b1) bad++;
        end
        chk("t3_wr_hold", bad, 0);
        mem_ok = 1'b1; eww = 1'b1; tick();
        chk("t3_ww", {st(), mem_req}, {S_WW, 1'b1});
        tick();
        chk("t3_ww_wait", {st(), mem_req}, {S_WW, 1'b1});
        mem_ok = 1'b1; ekc_2 = 1'b1; tick();
        chk("t3_end", {st(), kc, mem_req}, {S_IDLE, 2'b10});

        // 4: rejected memory cycle, alone and with mem_ok
        go_pp();
        got = 1'b1; ewr = 1'b1; tick();
        mem_no = 1'b1; tick();
        chk("t4_no", {st(), alarm, kc}, {S_IDLE, 2'b10});
        tick();
        chk("t4_alarm_pulse", alarm, 1'b0);
        go_pp();
        got = 1'b1; ewr = 1'b1; tick();
        mem_ok = 1'b1; mem_no = 1'b1; ekc_1 = 1'b1; tick();
        chk("t4_both", {st(), alarm, kc}, {S_IDLE, 2'b10});

        // 5: conflicting and absent requests
        go_pp();
        got = 1'b1; ewa = 1'b1; ewp = 1'b1; tick();
        chk("t5_prio", {st(), seq_err}, {S_WP, 1'b1});
        mem_ok = 1'b1; ewa = 1'b1; tick();
        chk("t5_ok_ignored", {st(), seq_err}, {S_WP, 1'b0});
        start = 1'b1; tick();
        chk("t5_start_busy", {st(), seq_err}, {S_WP, 1'b1});
        got = 1'b1; tick();
        chk("t5_noreq", {st(), seq_err, kc}, {S_IDLE, 2'b10});
        go_pp();
        got = 1'b1; ekc_1 = 1'b1; ewa = 1'b1; tick();
        chk("t5_ekc_wins", {st(), seq_err, kc}, {S_IDLE, 2'b11});

        // 6: waiting in WW
        go_pp();
        got = 1'b1; eww = 1'b1; tick();
`ifdef EXEC_TIMEOUT_EN
        tick(); tick(); tick();
        chk("t6_to_wait", {st(), alarm}, {S_WW, 1'b0});
        tick();
        chk("t6_timeout", {st(), alarm, kc}, {S_IDLE, 2'b10});
`else
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (st() != S_WW || alarm !== 1'b0) bad++;
        end
        chk("t6_no_timeout", bad, 0);
        abort = 1'b1; tick();
        chk("t6_abort", {st(), alarm, kc}, {S_IDLE, 2'b00});
`endif
        go_pp();
        got = 1'b1; eww = 1'b1; tick();
        tick();
        abort = 1'b1; mem_ok = 1'b1; ekc_1 = 1'b1; tick();
        chk("t6_abort_ww", {st(), alarm, kc}, {S_IDLE, 2'b00});
        go_pp();
        got = 1'b1; eww = 1'b1; tick();
        tick();
        clr = 1'b1; #1;
        chk("t6_clr_async", {st(), alarm, kc}, {S_IDLE, 2'b00});
        tick();
        clr = 1'b0;
        tick();
        tick(); tick(); tick(); tick();
        chk("t6_clr_quiet", {st(), alarm}, {S_IDLE, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
